// File: rtl/axi_wr_burst_ctrl.sv
// Drains a first-word-fall-through write buffer into AXI4 write bursts, one burst outstanding.
// Full bursts launch at BURST_LEN words; flush drains whatever is left as a shorter burst.
module axi_wr_burst_ctrl #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 32,
  parameter int BUFSIZE   = 6,
  parameter int BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] cfg_base,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              flush,
  input  logic              buf_we,
  input  logic              buf_isfull,
  input  logic              buf_isempty,
  input  logic [DWIDTH-1:0] buf_rdata,
  output logic              buf_re,
  output logic [AWIDTH-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic              awvalid,
  input  logic              awready,
  output logic [DWIDTH-1:0] wdata,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              busy,
  output logic              err,
  output logic [BUFSIZE:0]  occ
);

  localparam int               BYTES     = DWIDTH / 8;
  localparam logic [BUFSIZE:0] BURST_OCC = (BUFSIZE+1)'(BURST_LEN);
  localparam logic [BUFSIZE:0] OCC_ONE   = (BUFSIZE+1)'(1);
  localparam logic [BUFSIZE:0] OCC_ZERO  = (BUFSIZE+1)'(0);
  localparam logic [7:0]       FULL_LEN  = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_r, state_nx_s;
  logic              enable_r, stop_pend_r, err_r, awvalid_r, bready_r;
  logic [AWIDTH-1:0] awaddr_r, step_bytes_s;
  logic [7:0]        awlen_r, beat_r, len_s;
  logic [BUFSIZE:0]  occ_r;
  logic              push_s, pop_s, launch_s;
  logic              wvalid_s, wlast_s, buf_re_s;
  logic              aw_hs_s, w_hs_s, b_hs_s;

  assign wvalid_s     = (state_r == DATA) && !buf_isempty;
  assign wlast_s      = (state_r == DATA) && (beat_r == awlen_r);
  assign w_hs_s       = wvalid_s && wready;
  assign buf_re_s     = w_hs_s;
  assign aw_hs_s      = awvalid_r && awready;
  assign b_hs_s       = bready_r && bvalid;
  assign push_s       = buf_we && !buf_isfull;
  assign pop_s        = buf_re_s && !buf_isempty;
  assign launch_s     = enable_r && ((occ_r >= BURST_OCC) || (flush && (occ_r != OCC_ZERO)));
  assign step_bytes_s = (AWIDTH'(awlen_r) + AWIDTH'(1'b1)) * AWIDTH'(BYTES);

  // Burst length committed at launch: a full burst, or everything currently held.
  always_comb begin
    len_s = FULL_LEN;
    if (occ_r >= BURST_OCC) begin
      len_s = FULL_LEN;
    end else begin
      len_s = 8'(occ_r - OCC_ONE);
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    if (launch_s)            state_nx_s = ADDR; else state_nx_s = IDLE;
      ADDR:    if (aw_hs_s)             state_nx_s = DATA; else state_nx_s = ADDR;
      DATA:    if (w_hs_s && wlast_s)   state_nx_s = RESP; else state_nx_s = DATA;
      RESP:    if (b_hs_s)              state_nx_s = IDLE; else state_nx_s = RESP;
      default:                          state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Occupancy shadow of the buffer; a simultaneous push and pop cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r <= OCC_ZERO;
    end else begin
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Enable, deferred stop and sticky error; a stop seen mid-burst lands on the B handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_r    <= 1'b0;
      stop_pend_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (state_r == IDLE) begin
        stop_pend_r <= 1'b0;
        if (cfg_start) begin
          enable_r <= 1'b1;
        end else if (cfg_stop) begin
          enable_r <= 1'b0;
        end
      end else if (b_hs_s) begin
        stop_pend_r <= 1'b0;
        if (stop_pend_r || cfg_stop) begin
          enable_r <= 1'b0;
        end
      end else if (cfg_stop) begin
        stop_pend_r <= 1'b1;
      end
      if (b_hs_s && (bresp != 2'b00)) begin
        err_r <= 1'b1;
      end
    end
  end

  // Burst address, length, beat count and AW/B handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      awaddr_r  <= '0;
      awlen_r   <= 8'd0;
      awvalid_r <= 1'b0;
      bready_r  <= 1'b0;
      beat_r    <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cfg_start) awaddr_r <= cfg_base;
          if (launch_s) begin
            awlen_r   <= len_s;
            awvalid_r <= 1'b1;
          end
        end
        ADDR: begin
          beat_r <= 8'd0;
          if (aw_hs_s) awvalid_r <= 1'b0;
        end
        DATA: begin
          if (w_hs_s) begin
            beat_r <= beat_r + 8'd1;
            if (wlast_s) bready_r <= 1'b1;
          end
        end
        RESP: begin
          if (b_hs_s) begin
            bready_r <= 1'b0;
            awaddr_r <= awaddr_r + step_bytes_s;
          end
        end
        default: begin
          awvalid_r <= 1'b0;
          bready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign buf_re  = buf_re_s;
  assign awaddr  = awaddr_r;
  assign awlen   = awlen_r;
  assign awvalid = awvalid_r;
  assign wdata   = buf_rdata;
  assign wlast   = wlast_s;
  assign wvalid  = wvalid_s;
  assign bready  = bready_r;
  assign busy    = (state_r != IDLE);
  assign err     = err_r;
  assign occ     = occ_r;

endmodule

// File: tb/tb_axi_wr_burst_ctrl.sv
// Bench for axi_wr_burst_ctrl: FWFT buffer model, AXI slave with optional stalls,
// table of burst scenarios plus hand-written stall / error / stop / reset sequences.
module tb_axi_wr_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst, cfg_start, cfg_stop, flush, buf_we;
  logic        buf_isfull, buf_isempty, buf_re;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready, busy, err;
  logic [31:0] cfg_base, buf_rdata, awaddr, wdata, buf_wdata;
  logic [7:0]  awlen;
  logic [1:0]  bresp;
  logic [6:0]  occ;

  always #5 clk = ~clk;

  axi_wr_burst_ctrl #(.DWIDTH(32), .AWIDTH(32), .BUFSIZE(6), .BURST_LEN(16)) dut (
    .clk(clk), .rst(rst), .cfg_base(cfg_base), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .flush(flush), .buf_we(buf_we), .buf_isfull(buf_isfull), .buf_isempty(buf_isempty),
    .buf_rdata(buf_rdata), .buf_re(buf_re), .awaddr(awaddr), .awlen(awlen),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready), .busy(busy),
    .err(err), .occ(occ)
  );

  int checks = 0;
  int errors = 0;

  // buffer model: 63-word FWFT FIFO, reset together with the DUT
  logic [31:0] fmem [0:63];
  logic [5:0]  frp = 6'd0, fwp = 6'd0;
  logic [6:0]  fcnt = 7'd0;
  assign buf_isfull  = (fcnt == 7'd63);
  assign buf_isempty = (fcnt == 7'd0);
  assign buf_rdata   = fmem[frp];

  always @(posedge clk) begin
    if (rst) begin
      frp <= 6'd0; fwp <= 6'd0; fcnt <= 7'd0;
    end else begin
      if (buf_we && !buf_isfull) begin
        fmem[fwp] <= buf_wdata;
        fwp <= fwp + 6'd1;
      end
      if (buf_re && !buf_isempty) frp <= frp + 6'd1;
      fcnt <= fcnt + 7'(buf_we && !buf_isfull) - 7'(buf_re && !buf_isempty);
    end
  end

  // AXI slave
  bit         stall_en = 1'b0, wready_hold = 1'b0, b_pend = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;

  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = wready_hold ? 1'b0 : (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
      bvalid  = b_pend && (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
      bresp   = bresp_cfg;
    end
  end

  // monitor: logs handshakes seen ahead of the coming edge, counts protocol anomalies
  logic [31:0] aw_addr_log [0:63];
  logic [7:0]  aw_len_log  [0:63];
  logic [31:0] w_data_log  [0:511];
  logic        w_last_log  [0:511];
  int n_aw = 0, n_w = 0, beat_mon = 0, out_cnt = 0, occ_mis = 0, ovl_cnt = 0, re_bad = 0;

  always @(negedge clk) begin
    if (rst) begin
      b_pend <= 1'b0; beat_mon <= 0; out_cnt <= 0;
    end else begin
      if (occ !== fcnt) occ_mis <= occ_mis + 1;
      if (awvalid && out_cnt != 0) ovl_cnt <= ovl_cnt + 1;
      if ((wvalid && wready) !== buf_re) re_bad <= re_bad + 1;
      if (awvalid && awready) begin
        aw_addr_log[n_aw[5:0]] <= awaddr;
        aw_len_log[n_aw[5:0]]  <= awlen;
        n_aw <= n_aw + 1;
      end
      if (wvalid && wready) begin
        w_data_log[n_w[8:0]] <= wdata;
        w_last_log[n_w[8:0]] <= wlast;
        n_w <= n_w + 1;
        if (wlast) begin
          beat_mon <= 0; b_pend <= 1'b1;
        end else begin
          beat_mon <= beat_mon + 1;
        end
      end
      if (bvalid && bready) b_pend <= 1'b0;
      out_cnt <= out_cnt + ((awvalid && awready) ? 1 : 0) - ((bvalid && bready) ? 1 : 0);
    end
  end

  logic [31:0] push_val = 32'd0;
  logic [31:0] exp_rd   = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      buf_wdata = push_val; buf_we = 1'b1;
      step();
      push_val++;
    end
    buf_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] base);
    cfg_base = base; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  // waits for 8 consecutive idle cycles with no response pending
  task automatic wait_quiet(input int max);
    int q = 0;
    int t = 0;
    while (q < 8 && t < max) begin
      step(); t++;
      if (!busy && !b_pend) q++; else q = 0;
    end
    chk("settle", q, 8);
  endtask

  // every logged beat since (aw0,w0) must carry the next pushed word, wlast on the final beat
  task automatic verify_bursts(input int aw0, input int w0);
    int idx = w0;
    for (int k = aw0; k < n_aw; k++) begin
      for (int j = 0; j <= int'(aw_len_log[k[5:0]]); j++) begin
        chk("wdata", w_data_log[idx[8:0]], exp_rd);
        chk("wlast", 32'(w_last_log[idx[8:0]]), (j == int'(aw_len_log[k[5:0]])) ? 32'd1 : 32'd0);
        exp_rd++; idx++;
      end
    end
    chk("beat_count", n_w, idx);
  endtask

  typedef struct {
    int          n_push;
    bit          flush;
    int          exp_len;   // -1: no burst expected
    logic [31:0] exp_addr;
    int          exp_occ;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs [0:5];
  int   aw0, w0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16, 1'b0, 15, 32'h1000, 0, 32'h1040};
    vecs[1] = '{ 5, 1'b0, -1, 32'h0000, 5, 32'h1040};
    vecs[2] = '{ 0, 1'b1,  4, 32'h1040, 0, 32'h1054};
    vecs[3] = '{20, 1'b0, 15, 32'h1054, 4, 32'h1094};
    vecs[4] = '{ 0, 1'b1,  3, 32'h1094, 0, 32'h10A4};
    vecs[5] = '{ 1, 1'b1,  0, 32'h10A4, 0, 32'h10A8};

    rst = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; flush = 1'b0; buf_we = 1'b0;
    cfg_base = 32'd0; buf_wdata = 32'd0;
    repeat (3) step();
    chk("rst_busy", busy, 0);       chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);   chk("rst_bready", bready, 0);
    chk("rst_buf_re", buf_re, 0);   chk("rst_occ", occ, 0);
    chk("rst_err", err, 0);         chk("rst_awaddr", awaddr, 0);
    chk("rst_awlen", awlen, 0);
    rst = 1'b0;
    step();

    pulse_start(32'h1000);
    for (int i = 0; i < 6; i++) begin
      aw0 = n_aw; w0 = n_w;
      flush = vecs[i].flush;
      push_n(vecs[i].n_push);
      wait_quiet(300);
      chk("aw_count", n_aw - aw0, (vecs[i].exp_len < 0) ? 0 : 1);
      if (vecs[i].exp_len >= 0) begin
        chk("aw_addr", aw_addr_log[aw0[5:0]], vecs[i].exp_addr);
        chk("aw_len", aw_len_log[aw0[5:0]], vecs[i].exp_len);
      end
      chk("occ_after", occ, vecs[i].exp_occ);
      chk("next_awaddr", awaddr, vecs[i].exp_next);
      verify_bursts(aw0, w0);
      flush = 1'b0;
    end

    // random stalls on AW, W and B
    stall_en = 1'b1;
    aw0 = n_aw; w0 = n_w;
    push_n(40);
    wait_quiet(3000);
    chk("stall_aw_count", n_aw - aw0, 2);
    chk("stall_aw0_addr", aw_addr_log[aw0[5:0]], 32'h10A8);
    chk("stall_aw1_addr", aw_addr_log[6'(aw0 + 1)], 32'h10E8);
    chk("stall_occ", occ, 8);
    chk("stall_next_addr", awaddr, 32'h1128);
    verify_bursts(aw0, w0);
    stall_en = 1'b0;
    aw0 = n_aw; w0 = n_w;
    flush = 1'b1;
    wait_quiet(300);
    flush = 1'b0;
    chk("tail_aw_len", aw_len_log[aw0[5:0]], 7);
    chk("tail_occ", occ, 0);
    verify_bursts(aw0, w0);

    // error response is sticky across a later OKAY burst
    rst = 1'b1; step(); step(); rst = 1'b0;
    push_val = 32'd0; exp_rd = 32'd0;
    step();
    pulse_start(32'h2000);
    bresp_cfg = 2'b10;
    aw0 = n_aw; w0 = n_w;
    push_n(16);
    wait_quiet(300);
    chk("slverr_aw_addr", aw_addr_log[aw0[5:0]], 32'h2000);
    chk("err_set", err, 1);
    bresp_cfg = 2'b00;
    push_n(16);
    wait_quiet(300);
    chk("err_sticky", err, 1);
    chk("err_next_addr", awaddr, 32'h2080);
    verify_bursts(aw0, w0);

    // stop during DATA with 32 words queued; start while busy is ignored
    wready_hold = 1'b1;
    aw0 = n_aw; w0 = n_w;
    push_n(32);
    chk("stop_occ_queued", occ, 32);
    chk("stop_busy", busy, 1);
    pulse_start(32'hDEAD0000);
    chk("start_ignored_addr", awaddr, 32'h2080);
    cfg_stop = 1'b1; step(); cfg_stop = 1'b0;
    wready_hold = 1'b0;
    wait_quiet(300);
    repeat (30) step();
    chk("stop_aw_count", n_aw - aw0, 1);
    chk("stop_aw_addr", aw_addr_log[aw0[5:0]], 32'h2080);
    chk("stop_occ", occ, 16);
    chk("stop_next_addr", awaddr, 32'h20C0);
    verify_bursts(aw0, w0);
    aw0 = n_aw; w0 = n_w;
    pulse_start(32'h3000);
    wait_quiet(300);
    chk("restart_aw_addr", aw_addr_log[aw0[5:0]], 32'h3000);
    chk("restart_aw_len", aw_len_log[aw0[5:0]], 15);
    chk("restart_occ", occ, 0);
    verify_bursts(aw0, w0);

    // reset in the middle of a burst, at beat 7
    push_n(16);
    begin
      int t = 0;
      while (beat_mon != 7 && t < 200) begin step(); t++; end
      chk("beat7_reached", beat_mon, 7);
    end
    rst = 1'b1;
    step();
    chk("mid_rst_awvalid", awvalid, 0); chk("mid_rst_wvalid", wvalid, 0);
    chk("mid_rst_bready", bready, 0);   chk("mid_rst_busy", busy, 0);
    chk("mid_rst_occ", occ, 0);         chk("mid_rst_err", err, 0);
    chk("mid_rst_awaddr", awaddr, 0);
    rst = 1'b0; push_val = 32'd0; exp_rd = 32'd0;
    step();
    aw0 = n_aw;
    push_n(16);
    repeat (20) step();
    chk("disabled_after_rst", n_aw - aw0, 0);
    chk("disabled_occ", occ, 16);

    chk("occ_tracking_mismatches", occ_mis, 0);
    chk("aw_while_outstanding", ovl_cnt, 0);
    chk("buf_re_vs_w_handshake", re_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
